// File: rtl/rr_arbiter4_grant_low_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The master side drives enable and requests; the slave side returns the active-low grant word.
interface rr_arbiter4_grant_low_if;
    logic       e;
    logic [3:0] req;
    logic [3:0] gnt_n;
    logic [1:0] gidx;
    logic       busy;

    modport master (
        output e,
        output req,
        input  gnt_n,
        input  gidx,
        input  busy
    );

    modport slave (
        input  e,
        input  req,
        output gnt_n,
        output gidx,
        output busy
    );
endinterface

// File: rtl/rr_arbiter4_grant_low.sv
// Four-way round-robin arbiter with a registered active-low one-hot grant and bounded hold time.
// Every release goes through one IDLE cycle, so at most one grant line is ever low.
//
//   state | meaning
//   IDLE  | no grant driven; arbitrate requests starting at ptr when enabled
//   GRANT | grant held by gidx; release on drop, disable or hold-time expiry
module rr_arbiter4_grant_low #(
    parameter int MAX_HOLD = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    rr_arbiter4_grant_low_if.slave  bus
);

    localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        GRANT = 2'b10
    } state_t;

    state_t          state;
    logic [1:0]      ptr;
    logic [CW-1:0]   cnt;
    logic [3:0]      gnt_n_q;
    logic [1:0]      gidx_q;
    logic            busy_q;

    logic [1:0]      winner;
    logic [1:0]      cand;
    logic            any_req;
    logic            holder_req;
    logic            others_req;
    logic            hold_expired;
    logic            release_now;

    function automatic logic [3:0] dec_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Scan from the farthest offset back to ptr so the lowest offset with a request wins.
    always_comb begin
        winner = ptr;
        cand   = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (bus.req[cand]) begin
                winner = cand;
            end
        end
    end

    always_comb begin
        any_req      = |bus.req;
        holder_req   = bus.req[gidx_q];
        others_req   = |(bus.req & dec_n(gidx_q));
        hold_expired = (MAX_HOLD != 0) && (cnt >= HOLD_MAX);
        release_now  = !holder_req || (hold_expired && others_req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_n_q <= 4'b1111;
            gidx_q  <= 2'd0;
            busy_q  <= 1'b0;
            ptr     <= 2'd0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gnt_n_q <= 4'b1111;
                    busy_q  <= 1'b0;
                    if (!bus.e && any_req) begin
                        state   <= GRANT;
                        gnt_n_q <= dec_n(winner);
                        gidx_q  <= winner;
                        busy_q  <= 1'b1;
                        cnt     <= CNT_ONE;
                    end
                end
                GRANT: begin
                    if (bus.e) begin
                        // Disable keeps ptr, so the interrupted holder keeps priority.
                        state   <= IDLE;
                        gnt_n_q <= 4'b1111;
                        busy_q  <= 1'b0;
                    end else if (release_now) begin
                        state   <= IDLE;
                        gnt_n_q <= 4'b1111;
                        busy_q  <= 1'b0;
                        ptr     <= gidx_q + 2'd1;
                    end else if (cnt < HOLD_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt_n_q <= 4'b1111;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_n = gnt_n_q;
    assign bus.gidx  = gidx_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_rr_arbiter4_grant_low.sv
// Directed and randomized checks of the round-robin arbiter against a cycle-level
// reference model built from holder/pointer/hold-count bookkeeping.
module tb_rr_arbiter4_grant_low;

    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    rr_arbiter4_grant_low_if bus ();

    rr_arbiter4_grant_low #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: holder = -1 when nothing is granted.
    int m_holder = -1;
    int m_ptr    = 0;
    int m_last   = 0;
    int m_held   = 0;

    function automatic logic [3:0] exp_gnt();
        logic [3:0] g;
        g = 4'b1111;
        if (m_holder >= 0) g[m_holder] = 1'b0;
        return g;
    endfunction

    task automatic model_update();
        int others;
        if (rst) begin
            m_holder = -1; m_ptr = 0; m_last = 0; m_held = 0;
        end else if (m_holder < 0) begin
            if (!bus.e && bus.req != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_holder < 0 && bus.req[(m_ptr + k) % 4]) m_holder = (m_ptr + k) % 4;
                end
                m_last = m_holder;
                m_held = 1;
            end
        end else begin
            others = 0;
            for (int k = 0; k < 4; k++) if (k != m_holder && bus.req[k]) others = 1;
            if (bus.e) begin
                m_holder = -1;
            end else if (!bus.req[m_holder] || (m_held >= MAX_HOLD && others == 1)) begin
                m_ptr    = (m_holder + 1) % 4;
                m_holder = -1;
            end else if (m_held < MAX_HOLD) begin
                m_held = m_held + 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.e = 1'b0; bus.req = 4'b0000;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.e = 1'b0; bus.req = 4'b1111;
        step(); step();
        total++;
        if (bus.gnt_n !== 4'b1111) begin bad++; $display("FAIL reset_gnt: got %b want 1111", bus.gnt_n); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++;
        if (bus.gidx !== 2'd0) begin bad++; $display("FAIL reset_gidx: got %0d want 0", bus.gidx); end
        rst = 1'b0; bus.req = 4'b0000;
        step();
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0100;
        step();
        total++;
        if (bus.gnt_n !== 4'b1011 || bus.gidx !== 2'd2 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL single_grant: got gnt_n=%b gidx=%0d busy=%b want 1011/2/1", bus.gnt_n, bus.gidx, bus.busy);
        end
        bus.req = 4'b0000;
        step();
        total++;
        if (bus.gnt_n !== 4'b1111 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL single_release: got gnt_n=%b busy=%b want 1111/0", bus.gnt_n, bus.busy);
        end
        // ptr should now be 3, so index 3 wins when everybody asks.
        bus.req = 4'b1111;
        step();
        total++;
        if (bus.gnt_n !== 4'b0111 || bus.gidx !== 2'd3) begin
            bad++; $display("FAIL single_ptr_next: got gnt_n=%b gidx=%0d want 0111/3", bus.gnt_n, bus.gidx);
        end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_rotation();
        logic [3:0] want;
        do_reset();
        bus.req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            want = 4'b1111;
            want[k % 4] = 1'b0;
            total++;
            if (bus.gnt_n !== want) begin bad++; $display("FAIL rotation_grant%0d: got %b want %b", k, bus.gnt_n, want); end
            step();
            total++;
            if (bus.gnt_n !== want) begin bad++; $display("FAIL rotation_hold%0d: got %b want %b", k, bus.gnt_n, want); end
            bus.req[k % 4] = 1'b0;
            step();
            total++;
            if (bus.gnt_n !== 4'b1111 || bus.busy !== 1'b0) begin
                bad++; $display("FAIL rotation_gap%0d: got gnt_n=%b busy=%b want 1111/0", k, bus.gnt_n, bus.busy);
            end
            bus.req = 4'b1111;
            step();
        end
        bus.req = 4'b0000;
        step(); step();
    endtask

    task automatic test_forced_release();
        int held_ok;
        do_reset();
        bus.req = 4'b1010;
        step();
        held_ok = 1;
        for (int k = 0; k < MAX_HOLD; k++) begin
            if (bus.gnt_n !== 4'b1101) held_ok = 0;
            if (k < MAX_HOLD - 1) step();
        end
        total++;
        if (held_ok != 1) begin bad++; $display("FAIL forced_hold: got last %b want 1101 for %0d cycles", bus.gnt_n, MAX_HOLD); end
        step();
        total++;
        if (bus.gnt_n !== 4'b1111) begin bad++; $display("FAIL forced_gap: got %b want 1111", bus.gnt_n); end
        step();
        total++;
        if (bus.gnt_n !== 4'b0111) begin bad++; $display("FAIL forced_next: got %b want 0111", bus.gnt_n); end
        bus.req = 4'b0010;
        step(); step();
        held_ok = 1;
        for (int k = 0; k < 20; k++) begin
            if (bus.gnt_n !== 4'b1101) held_ok = 0;
            step();
        end
        total++;
        if (held_ok != 1) begin bad++; $display("FAIL forced_alone_hold: got %b want 1101 throughout", bus.gnt_n); end
        bus.req = 4'b0000;
        step(); step();
    endtask

    task automatic test_enable();
        do_reset();
        bus.req = 4'b0001;
        step();
        total++;
        if (bus.gnt_n !== 4'b1110) begin bad++; $display("FAIL enable_grant0: got %b want 1110", bus.gnt_n); end
        bus.e = 1'b1;
        step();
        total++;
        if (bus.gnt_n !== 4'b1111 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL enable_off: got gnt_n=%b busy=%b want 1111/0", bus.gnt_n, bus.busy);
        end
        bus.e = 1'b0; bus.req = 4'b1001;
        step();
        total++;
        if (bus.gnt_n !== 4'b1110 || bus.gidx !== 2'd0) begin
            bad++; $display("FAIL enable_regrant: got gnt_n=%b gidx=%0d want 1110/0", bus.gnt_n, bus.gidx);
        end
        bus.req = 4'b0000;
        step(); step();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        bus.req = 4'b1000;
        step();
        total++;
        if (bus.gnt_n !== 4'b0111) begin bad++; $display("FAIL midrst_grant3: got %b want 0111", bus.gnt_n); end
        rst = 1'b1;
        step();
        total++;
        if (bus.gnt_n !== 4'b1111 || bus.gidx !== 2'd0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL midrst_clear: got gnt_n=%b gidx=%0d busy=%b want 1111/0/0", bus.gnt_n, bus.gidx, bus.busy);
        end
        rst = 1'b0; bus.req = 4'b1010;
        step();
        total++;
        if (bus.gnt_n !== 4'b1101 || bus.gidx !== 2'd1) begin
            bad++; $display("FAIL midrst_next: got gnt_n=%b gidx=%0d want 1101/1", bus.gnt_n, bus.gidx);
        end
        bus.req = 4'b0000;
        step(); step();
    endtask

    task automatic test_random();
        logic [3:0] want;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 59) == 0);
            bus.e = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
            step();
            want = exp_gnt();
            total++;
            if (bus.gnt_n !== want) begin bad++; $display("FAIL rand_gnt c=%0d: got %b want %b", c, bus.gnt_n, want); end
            total++;
            if (bus.gidx !== 2'(m_last)) begin bad++; $display("FAIL rand_gidx c=%0d: got %0d want %0d", c, bus.gidx, m_last); end
            total++;
            if (bus.busy !== (m_holder >= 0)) begin bad++; $display("FAIL rand_busy c=%0d: got %b want %b", c, bus.busy, m_holder >= 0); end
        end
        rst = 1'b0; bus.e = 1'b0; bus.req = 4'b0000;
        step(); step();
    endtask

    initial begin
        bus.e   = 1'b0;
        bus.req = 4'b0000;
        test_reset();
        test_single();
        test_rotation();
        test_forced_release();
        test_enable();
        test_reset_mid_grant();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
